// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream multiplexer.
package stream_mux_pkg;

   typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;

   // Wrap by compare so non-power-of-2 channel counts never reach index n.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward with wrap; ptr moves past each granted winner.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              grant_any
);

   logic [SEL_W-1:0] ptr_q;

   // Walk offsets from highest to lowest so the closest request to ptr wins.
   always_comb begin
      int cand;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
         cand = int'(32'(ptr_q)) + k;
         if (cand >= int'(NUM_CH)) begin
            cand = cand - int'(NUM_CH);
         end
         if (req[cand]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (advance && grant_any) begin
         ptr_q <= SEL_W'(next_idx(32'(grant_idx), NUM_CH));
      end
   end

endmodule

// File: rtl/stream_mux.sv
// N-channel registered stream multiplexer with fixed-select or round-robin arbitration.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 8,
   localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  mux_mode_e                mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [SEL_W-1:0]  out_ch_q;

   logic              rr_any;
   logic [SEL_W-1:0]  rr_idx;
   logic              fixed_any;
   logic              grant_any;
   logic [SEL_W-1:0]  grant_idx;
   logic              load;
   logic              xfer;
   logic              advance;
   logic [DATA_W-1:0] grant_data;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (advance),
      .grant_idx (rr_idx),
      .grant_any (rr_any)
   );

   // sel may address a channel that does not exist when NUM_CH is not a power of 2.
   always_comb begin
      fixed_any = 1'b0;
      if (32'(sel) < NUM_CH) begin
         fixed_any = in_valid[sel];
      end
   end

   always_comb begin
      grant_any = fixed_any;
      grant_idx = sel;
      if (mode == MODE_RR) begin
         grant_any = rr_any;
         grant_idx = rr_idx;
      end
   end

   assign load       = !out_valid_q || out_ready;
   assign xfer       = load && grant_any && !rst;
   assign advance    = xfer && (mode == MODE_RR);
   assign grant_data = in_data[grant_idx*DATA_W +: DATA_W];

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         in_ready[i] = xfer && (32'(grant_idx) == 32'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else if (load) begin
         out_valid_q <= grant_any;
         if (grant_any) begin
            out_data_q <= grant_data;
            out_ch_q   <= grant_idx;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Randomized self-checking bench for stream_mux against a queue-free behavioural model.
module tb_stream_mux;
   import stream_mux_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-channel instance
   logic        rst;
   mux_mode_e   mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready;

   // 3-channel instance
   logic        rst3;
   mux_mode_e   mode3;
   logic [1:0]  sel3;
   logic [2:0]  in_valid3;
   logic [23:0] in_data3;
   logic [2:0]  in_ready3;
   logic        out_valid3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_ready3;

   int checks   = 0;
   int failures = 0;

   // Reference state for the 4-channel instance
   bit         m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   int         m_ch    = 0;
   int         m_ptr   = 0;

   stream_mux #(.NUM_CH(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
      .clk       (clk),
      .rst       (rst3),
      .mode      (mode3),
      .sel       (sel3),
      .in_valid  (in_valid3),
      .in_data   (in_data3),
      .in_ready  (in_ready3),
      .out_valid (out_valid3),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .out_ready (out_ready3)
   );

   function automatic void m_grant(output bit any, output int g);
      any = 1'b0;
      g   = 0;
      if (mode == MODE_FIXED) begin
         if (int'(sel) < 4 && in_valid[sel]) begin
            any = 1'b1;
            g   = int'(sel);
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            int c = (m_ptr + k) % 4;
            if (!any && in_valid[c]) begin
               any = 1'b1;
               g   = c;
            end
         end
      end
   endfunction

   function automatic logic [3:0] m_ready();
      bit any;
      int g;
      m_grant(any, g);
      if (rst || !any || (m_valid && !out_ready)) return 4'b0000;
      return 4'(1 << g);
   endfunction

   task automatic tick();
      bit any;
      int g;
      @(posedge clk);
      m_grant(any, g);
      if (rst) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ch    = 0;
         m_ptr   = 0;
      end else if (!m_valid || out_ready) begin
         m_valid = any;
         if (any) begin
            m_data = in_data[g*8 +: 8];
            m_ch   = g;
            if (mode == MODE_RR) m_ptr = (g + 1) % 4;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      mode      = MODE_FIXED;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=0000", in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset_out got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                     out_valid, out_data, out_ch);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL reset_release_ready got=%b want=0001", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd0) begin
         failures++;
         $display("FAIL reset_first_beat got v=%b d=%h ch=%0d want v=1 d=11 ch=0",
                  out_valid, out_data, out_ch);
      end
   endtask

   task automatic test_fixed();
      mode     = MODE_FIXED;
      sel      = 2'd2;
      in_valid = 4'b1111;
      in_data  = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         failures++;
         $display("FAIL fixed_ready got=%b want=0100", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
         failures++;
         $display("FAIL fixed_beat got v=%b d=%h ch=%0d want v=1 d=a5 ch=2",
                  out_valid, out_data, out_ch);
      end
      sel      = 2'd3;
      in_valid = 4'b0111;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL fixed_invalid_ready got=%b want=0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
         failures++;
         $display("FAIL fixed_drop got v=%b d=%h ch=%0d want v=0 d=a5 ch=2",
                  out_valid, out_data, out_ch);
      end
   endtask

   task automatic test_round_robin();
      int want;
      mode     = MODE_RR;
      in_valid = 4'b1111;
      in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int i = 0; i < 8; i++) begin
         want = i % 4;
         #1;
         checks++;
         if (in_ready !== 4'(1 << want)) begin
            failures++;
            $display("FAIL rr_ready[%0d] got=%b want=%b", i, in_ready, 4'(1 << want));
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || int'(out_ch) != want || out_data !== 8'(8'h10 + want)) begin
            failures++;
            $display("FAIL rr_seq[%0d] got ch=%0d d=%h want ch=%0d d=%h",
                     i, out_ch, out_data, want, 8'(8'h10 + want));
         end
      end
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         want = (i % 2 == 0) ? 1 : 3;
         tick();
         checks++;
         if (out_valid !== 1'b1 || int'(out_ch) != want) begin
            failures++;
            $display("FAIL rr_alt[%0d] got ch=%0d want ch=%0d", i, out_ch, want);
         end
      end
   endtask

   task automatic test_backpressure();
      mode      = MODE_FIXED;
      sel       = 2'd1;
      in_valid  = 4'b1111;
      in_data   = {8'h44, 8'h22, 8'h11, 8'h00};
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd1) begin
         failures++;
         $display("FAIL bp_load got v=%b d=%h ch=%0d want v=1 d=11 ch=1",
                  out_valid, out_data, out_ch);
      end
      out_ready = 1'b0;
      sel       = 2'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_ready[%0d] got=%b want=0000", i, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd1) begin
            failures++;
            $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d want v=1 d=11 ch=1",
                     i, out_valid, out_data, out_ch);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         failures++;
         $display("FAIL bp_release_ready got=%b want=0100", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ch !== 2'd2) begin
         failures++;
         $display("FAIL bp_no_bubble got v=%b d=%h ch=%0d want v=1 d=22 ch=2",
                  out_valid, out_data, out_ch);
      end
   endtask

   task automatic test_mid_reset();
      mode      = MODE_RR;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_ready got=%b want=0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_valid got=%b want=0", out_valid);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL midrst_restart_ready got=%b want=0001", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
         failures++;
         $display("FAIL midrst_restart got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch);
      end
   endtask

   task automatic test_random();
      logic [3:0] want_ready;
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 31) == 0);
         mode      = mux_mode_e'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         want_ready = m_ready();
         checks++;
         if (in_ready !== want_ready) begin
            failures++;
            $display("FAIL rand_ready[%0d] got=%b want=%b", i, in_ready, want_ready);
         end
         tick();
         checks++;
         if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch) begin
            failures++;
            $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                     i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_non_pow2();
      int want;
      rst3 = 1'b1;
      @(posedge clk);
      #1;
      rst3       = 1'b0;
      mode3      = MODE_RR;
      in_valid3  = 3'b111;
      in_data3   = {8'h22, 8'h21, 8'h20};
      out_ready3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         want = i % 3;
         @(posedge clk);
         #1;
         checks++;
         if (out_valid3 !== 1'b1 || int'(out_ch3) != want || out_data3 !== 8'(8'h20 + want)) begin
            failures++;
            $display("FAIL npot_rr[%0d] got ch=%0d d=%h want ch=%0d d=%h",
                     i, out_ch3, out_data3, want, 8'(8'h20 + want));
         end
      end
      mode3 = MODE_FIXED;
      sel3  = 2'd3;
      #1;
      checks++;
      if (in_ready3 !== 3'b000) begin
         failures++;
         $display("FAIL npot_sel3_ready got=%b want=000", in_ready3);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid3 !== 1'b0) begin
         failures++;
         $display("FAIL npot_sel3_valid got=%b want=0", out_valid3);
      end
   endtask

   initial begin
      rst3       = 1'b1;
      mode3      = MODE_FIXED;
      sel3       = 2'd0;
      in_valid3  = 3'b000;
      in_data3   = '0;
      out_ready3 = 1'b1;
      test_reset();
      test_fixed();
      test_round_robin();
      test_backpressure();
      test_mid_reset();
      test_random();
      test_non_pow2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
